// File: rtl/tl_mem_responder.sv
// Single-beat TileLink-UL memory slave: Get/PutFull/PutPartial against a small
// word memory, responses returned through a DEPTH-entry in-order queue.
// Ports: clock/resetn, A channel (a_*) in with a_ready out,
//        D channel (d_*) out with d_ready in.
module tl_mem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h0001_0000,
  parameter int          MEM_WORDS = 16,
  parameter int          DEPTH     = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic [1:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic [1:0]  d_source,
  output logic [1:0]  d_sink,
  output logic [1:0]  d_addr_lo,
  output logic [31:0] d_data,
  output logic        d_error
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [1:0]  source;
    logic [1:0]  addr_lo;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  rsp_t          q_q   [DEPTH];
  logic [31:0]   mem_q [MEM_WORDS];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  logic          full, empty, push, pop;
  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          in_range, aligned, ok;
  logic          is_get, is_put, wr_en;
  rsp_t          new_rsp, head;
  logic          unused_bits;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign a_ready = !full;
  assign d_valid = !empty;
  assign push    = a_valid && a_ready;
  assign pop     = d_valid && d_ready;

  // Unsigned subtract: addresses below the base wrap to huge offsets
  // and fail the word-index bound, and are also rejected explicitly.
  assign offset   = a_address - ADDR_BASE;
  assign idx      = offset[IW+1:2];
  assign in_range = (a_address >= ADDR_BASE)
                 && (offset[31:2] < 30'(MEM_WORDS));

  always_comb begin
    aligned = 1'b0;
    unique case (a_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = !a_address[0];
      4'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign ok     = in_range && aligned && (a_size <= 4'd2);
  assign is_get = (a_opcode == 3'd4);
  assign is_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign wr_en  = push && is_put && ok;

  always_comb begin
    new_rsp         = '0;
    new_rsp.opcode  = is_get ? 3'd1 : 3'd0;
    new_rsp.size    = a_size;
    new_rsp.source  = a_source;
    new_rsp.addr_lo = a_address[1:0];
    new_rsp.data    = (is_get && ok) ? mem_q[idx] : 32'h0;
    new_rsp.error   = !((is_get || is_put) && ok);
  end

  // Bits beyond the head are forced to zero whenever the queue is
  // empty so stale entries never leak onto the D channel.
  assign head      = d_valid ? q_q[rd_q] : '0;
  assign d_opcode  = head.opcode;
  assign d_size    = head.size;
  assign d_source  = head.source;
  assign d_addr_lo = head.addr_lo;
  assign d_data    = head.data;
  assign d_error   = head.error;
  assign d_param   = 2'd0;
  assign d_sink    = 2'd0;

  assign unused_bits = ^{a_param, offset[1:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      if (push) begin
        q_q[wr_q] <= new_rsp;
        wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed self-checking bench for tl_mem_responder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_tl_mem_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [1:0]  d_source;
  logic [1:0]  d_sink;
  logic [1:0]  d_addr_lo;
  logic [31:0] d_data;
  logic        d_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [48:0] rsp;
  logic [48:0] want;

  assign rsp = {d_valid, d_opcode, d_param, d_size, d_source,
                d_sink, d_addr_lo, d_error, d_data};

  always #5 clock = ~clock;

  tl_mem_responder dut (
    .clock(clock), .resetn(resetn),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_addr_lo(d_addr_lo),
    .d_data(d_data), .d_error(d_error)
  );

  function automatic logic [48:0] exp_r(
    input logic v, input logic [2:0] op, input logic [3:0] sz,
    input logic [1:0] src, input logic [1:0] alo,
    input logic err, input logic [31:0] dat);
    exp_r = {v, op, 2'b00, sz, src, 2'b00, alo, err, dat};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] addr,
                       input logic [3:0] sz, input logic [1:0] src,
                       input logic [3:0] mask, input logic [31:0] dat);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'd0;
    a_address = addr;
    a_size    = sz;
    a_source  = src;
    a_mask    = mask;
    a_data    = dat;
  endtask

  task automatic idle();
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_param   = 3'd0;
    a_address = 32'h0;
    a_size    = 4'd0;
    a_source  = 2'd0;
    a_mask    = 4'h0;
    a_data    = 32'h0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    d_ready = 1'b0;
    idle();
    repeat (2) @(negedge clock);
    n_checks++;
    if (rsp !== 49'h0) begin
      n_fail++;
      $display("FAIL reset_d_outputs: got %h want 0", rsp);
    end
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: a_ready=%b d_valid=%b want 1/0",
               a_ready, d_valid);
    end
  endtask

  task automatic test_first_get();
    d_ready = 1'b1;
    drive(3'd4, 32'h0001_0004, 4'd2, 2'd1, 4'hF, 32'h0);
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd1, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL first_get: got %h want %h", rsp, want);
    end
    idle();
    @(negedge clock);
    n_checks++;
    if (d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_get_drain: d_valid=%b want 0", d_valid);
    end
  endtask

  task automatic test_put_partial();
    d_ready = 1'b1;
    drive(3'd0, 32'h0001_0008, 4'd2, 2'd0, 4'hF, 32'hDEAD_BEEF);
    @(negedge clock);
    want = exp_r(1, 3'd0, 4'd2, 2'd0, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL putfull_ack: got %h want %h", rsp, want);
    end
    drive(3'd1, 32'h0001_0008, 4'd2, 2'd2, 4'h2, 32'h0000_1200);
    @(negedge clock);
    want = exp_r(1, 3'd0, 4'd2, 2'd2, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL putpartial_ack: got %h want %h", rsp, want);
    end
    drive(3'd4, 32'h0001_0008, 4'd2, 2'd3, 4'hF, 32'h0);
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd3, 2'd0, 0, 32'hDEAD_12EF);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL merged_get: got %h want %h", rsp, want);
    end
    idle();
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    d_ready = 1'b0;
    drive(3'd4, 32'h0001_0008, 4'd2, 2'd0, 4'hF, 32'h0);
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready0: a_ready=%b want 1", a_ready);
    end
    @(negedge clock);
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready1: a_ready=%b want 1", a_ready);
    end
    drive(3'd4, 32'h0001_0004, 4'd2, 2'd1, 4'hF, 32'h0);
    @(negedge clock);
    drive(3'd0, 32'h0001_000C, 4'd2, 2'd2, 4'hF, 32'h1122_3344);
    want = exp_r(1, 3'd1, 4'd2, 2'd0, 2'd0, 0, 32'hDEAD_12EF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_checks++;
      if (rsp !== want || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h rdy=%b want %h rdy=0",
                 i, rsp, a_ready, want);
      end
    end
    d_ready = 1'b1;
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd1, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain1: got %h rdy=%b want %h rdy=1",
               rsp, a_ready, want);
    end
    @(negedge clock);
    want = exp_r(1, 3'd0, 4'd2, 2'd2, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL bp_third: got %h want %h", rsp, want);
    end
    drive(3'd4, 32'h0001_000C, 4'd2, 2'd3, 4'hF, 32'h0);
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd3, 2'd0, 0, 32'h1122_3344);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL bp_readback: got %h want %h", rsp, want);
    end
    idle();
    @(negedge clock);
    n_checks++;
    if (d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: d_valid=%b want 0", d_valid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5];
    logic [3:0]  sizes [5];
    logic        errs  [5];
    addrs = '{32'h0000_FFFC, 32'h0001_0040, 32'h0001_0002,
              32'h0001_0000, 32'h0001_003C};
    sizes = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd2};
    errs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    d_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(3'd4, addrs[i], sizes[i], 2'(i), 4'hF, 32'h0);
      @(negedge clock);
      want = exp_r(1, 3'd1, sizes[i], 2'(i), addrs[i][1:0],
                   errs[i], 32'h0);
      n_checks++;
      if (rsp !== want) begin
        n_fail++;
        $display("FAIL err_get%0d: got %h want %h", i, rsp, want);
      end
      idle();
      @(negedge clock);
    end
  endtask

  task automatic test_bad_opcode();
    d_ready = 1'b1;
    drive(3'd2, 32'h0001_0000, 4'd2, 2'd0, 4'hF, 32'hFFFF_FFFF);
    @(negedge clock);
    want = exp_r(1, 3'd0, 4'd2, 2'd0, 2'd0, 1, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL bad_op_ack: got %h want %h", rsp, want);
    end
    drive(3'd4, 32'h0001_0000, 4'd2, 2'd1, 4'hF, 32'h0);
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd1, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL bad_op_mem: got %h want %h", rsp, want);
    end
    idle();
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    d_ready = 1'b0;
    drive(3'd4, 32'h0001_0008, 4'd2, 2'd0, 4'hF, 32'h0);
    @(negedge clock);
    drive(3'd4, 32'h0001_000C, 4'd2, 2'd1, 4'hF, 32'h0);
    @(negedge clock);
    n_checks++;
    if (d_valid !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_prefill: d_valid=%b a_ready=%b want 1/0",
               d_valid, a_ready);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (rsp !== 49'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h want 0", rsp);
    end
    @(negedge clock);
    idle();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: a_ready=%b d_valid=%b want 1/0",
               a_ready, d_valid);
    end
    d_ready = 1'b1;
    drive(3'd4, 32'h0001_0008, 4'd2, 2'd2, 4'hF, 32'h0);
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd2, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL rst_mem8: got %h want %h", rsp, want);
    end
    drive(3'd4, 32'h0001_000C, 4'd2, 2'd3, 4'hF, 32'h0);
    @(negedge clock);
    want = exp_r(1, 3'd1, 4'd2, 2'd3, 2'd0, 0, 32'h0);
    n_checks++;
    if (rsp !== want) begin
      n_fail++;
      $display("FAIL rst_memC: got %h want %h", rsp, want);
    end
    idle();
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_first_get();
    test_put_partial();
    test_back_to_back();
    test_errors();
    test_bad_opcode();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_mem_responder.md
Name: tl_mem_responder

Overview:
- Single-beat TileLink-UL memory slave that sits directly upstream of the Rocket tile's master port in simulation benches and bounded formal runs.
- Consumes the tile's A channel (Get, PutFullData, PutPartialData) against a small internal word memory.
- Returns D-channel responses that always meet the tile's D-channel stability rules: valid and bits held stable until ready.

Parameters:
- ADDR_BASE, 32'h0001_0000, byte address of memory word 0 (matches the tile reset vector).
- MEM_WORDS, 16, number of 32-bit memory words; power of two, at least 2.
- DEPTH, 2, response queue entries; power of two, at least 1.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous reset, active low.
- a_valid  in  1  A-channel request valid.
- a_ready  out  1  A-channel accept.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get.
- a_param  in  3  ignored.
- a_size  in  4  log2 of transfer bytes.
- a_source  in  2  requester tag.
- a_address  in  32  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  D-channel response valid.
- d_ready  in  1  D-channel accept.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  4  echo of a_size.
- d_source  out  2  echo of a_source.
- d_sink  out  2  always 0.
- d_addr_lo  out  2  echo of a_address[1:0].
- d_data  out  32  read data; 0 for non-Get responses and for errors.
- d_error  out  1  request rejected.

Behaviour:
- Reset (resetn low, asynchronous):
  - Queue empty: d_valid=0, a_ready=1 as soon as reset releases.
  - All d_* bit outputs = 0.
  - All memory words = 0.
  - In-flight requests and queued responses are discarded; no partial write is committed.
- Handshake and queue:
  - Accept occurs when a_valid && a_ready. a_ready = !full. A full queue does not accept, even in the same cycle as a dequeue.
  - Each accept pushes exactly one response entry. Response order = accept order.
  - d_valid = !empty. Dequeue on d_valid && d_ready.
  - While d_valid is high and d_ready is low, all d_* outputs hold stable.
  - Simultaneous push and pop on a non-full, non-empty queue leaves the count unchanged.
  - Minimum latency: a request accepted at edge N shows d_valid high after edge N, with d_ready able to complete it at edge N+1. No combinational A-to-D path.
- Request decode, evaluated at accept:
  - idx = (a_address - ADDR_BASE) >> 2.
  - in_range = a_address >= ADDR_BASE && idx < MEM_WORDS.
  - aligned = a_address[a_size-1:0] == 0.
  - ok = in_range && aligned && a_size <= 2.
  - Get: d_opcode=1. If ok, d_data = mem[idx] sampled at the accept edge, d_error=0. Otherwise d_data=0, d_error=1.
  - PutFull or PutPartial: d_opcode=0, d_data=0. If ok, write mem[idx] bytes where a_mask[i]=1, at the accept edge, d_error=0. Otherwise no write, d_error=1. PutFull uses a_mask exactly as given; no mask legality check.
  - Any other opcode: d_opcode=0, d_data=0, d_error=1, no memory change.
- Ordering:
  - A Get accepted after a Put to the same word returns the written data.
  - A Get queued before a later Put returns the pre-write data, because data is captured at accept.
- Address arithmetic: addresses below ADDR_BASE must not wrap into range; the comparison is unsigned 32-bit.

Test Plan:
1. Reset, then Get @0x0001_0004 size 2 source 1 with d_ready=1 -> the next cycle gives d_valid=1, opcode=1, data=0, error=0, source=1, addr_lo=0.
2. PutFull @0x0001_0008 data 0xDEADBEEF mask 0xF, then PutPartial same address data 0x00001200 mask 0x2, then Get -> two AccessAcks (error=0), then AccessAckData data=0xDEAD12EF.
3. d_ready=0 with three back-to-back requests -> a_ready falls after 2 accepts (DEPTH=2). d_* stays stable for 5 held cycles. Releasing d_ready drains the responses in order and then accepts the third request.
4. Get @0x0000_FFFC, Get @0x0001_0040 (MEM_WORDS=16), Get @0x0001_0002 size 2, Get size 3 -> each returns error=1, data=0.
5. Opcode 2 (Arithmetic) @0x0001_0000 -> AccessAck with error=1, and a follow-up Get confirms the memory is unchanged.
6. Assert resetn low with 2 responses queued and a_valid high -> d_valid=0 immediately. After release, a_ready=1, the queue is empty, and memory reads 0.
